regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file; successor to the single-write, two-read register file.
- Adds: configurable width, depth and port counts; optional write-to-read bypass; per-register scoreboard busy bits for in-order issue hazard tracking; a registered busy-count output.
- Sits between decode/issue (read ports, issue marking) and writeback (write ports, busy clear).

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; power of two, minimum 2; AW = $clog2(NREG).
- NRD, 2, number of read ports, 1..4.
- NWR, 2, number of write ports, 1..4.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads; 0 = reads return the stored value only.
- ZERO_R0, 1, 1 = register 0 is hard-wired to zero, ignores writes and is never busy.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- raddr  in  NRD*AW  read addresses; port k is bits [k*AW +: AW]
- rdata  out  NRD*XLEN  read data, combinational from raddr
- rbusy  out  NRD  scoreboard busy bit of the addressed register, combinational
- wen  in  NWR  write enables, one per write port
- waddr  in  NWR*AW  write addresses
- wdata  in  NWR*XLEN  write data
- iss_en  in  1  mark register iss_addr busy at the next edge
- iss_addr  in  AW  destination register being issued
- flush  in  1  synchronous clear of all busy bits
- busy_cnt  out  $clog2(NREG+1)  registered population count of busy bits

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0, all busy bits = 0, busy_cnt = 0. While in reset, rdata = 0 and rbusy = 0 for every port. Writes, issues and flushes are ignored.
- Write: at the rising edge, for each port j with wen[j]=1, reg[waddr_j] <= wdata_j.
  - When ZERO_R0=1, writes to address 0 are dropped.
  - Multiple ports writing the same address in one cycle: the highest-indexed port wins.
- Read: rdata_k = reg[raddr_k] (combinational).
  - When ZERO_R0=1 and raddr_k=0, rdata_k = 0 regardless of BYPASS.
  - When BYPASS=1 and some enabled write port targets raddr_k, rdata_k = the winning port's wdata (same priority as the write rule).
- Scoreboard, next-state per register r:
  - flush=1: all busy bits <= 0. Flush overrides every set and clear this cycle.
  - Otherwise busy[r] <= (busy[r] & ~clr[r]) | set[r]:
    - set[r] = iss_en & (iss_addr == r);
    - clr[r] = OR over j of (wen[j] & waddr_j == r).
  - Issue and writeback to the same register in one cycle: set wins, so busy stays 1 because a new producer replaces the old one.
  - When ZERO_R0=1, busy[0] is held at 0.
- rbusy_k = busy[raddr_k], taken from the current registered state. No forwarding of same-cycle set or clear.
- busy_cnt: registered; at each edge it takes the popcount of the next-state busy vector. It therefore always equals the number of 1s in the busy vector.
- Latency:
  - Write visible to a non-bypassed read the cycle after the edge; to a bypassed read in the same cycle.
  - Busy set/clear visible on rbusy the cycle after the edge.
- No stalls or backpressure; every request is accepted every cycle.
- Reset asserted mid-operation overrides all pending writes, issues and flushes immediately.

Test Plan:
- Reset and zero register: rst=0 then release; read all addresses -> rdata=0, rbusy=0, busy_cnt=0. Write 0xDEADBEEF to r0 -> next cycle rdata(r0)=0, busy_cnt=0.
- Write/read with bypass: BYPASS=1; wen[0]=1, waddr=5, wdata=0x12345678; same cycle raddr0=5 -> rdata0=0x12345678. With BYPASS=0, same stimulus -> rdata0 = old value (0), then 0x12345678 next cycle.
- Write port conflict: wen=2'b11, both waddr=7, wdata0=0xAAAA0000, wdata1=0x5555FFFF -> r7=0x5555FFFF; the bypassed read that same cycle also returns 0x5555FFFF.
- Scoreboard sequence: iss r3, iss r4, then writeback r3 (cycles 1..3) -> rbusy(r3)=1,1,0 and busy_cnt=1,2,1. Then iss r4 with writeback r4 in the same cycle -> rbusy(r4) stays 1, busy_cnt=1.
- Flush priority: busy r1,r2,r9 set (busy_cnt=3); flush=1 with iss_en=1, iss_addr=10 -> next cycle all rbusy=0, busy_cnt=0.
- Asynchronous reset mid-operation: pull rst low between edges while wen=1 and iss_en=1 -> rdata, rbusy and busy_cnt go to 0 immediately. After release, the first edge with wen=0 and iss_en=0 leaves all registers 0.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with write bypass and issue scoreboard
// Writes resolve highest-port-wins; busy bits track in-flight producers per register.
module regfile_mp_sb #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1,
    localparam int AW     = $clog2(NREG),
    localparam int CW     = $clog2(NREG + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*XLEN-1:0]  rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic [NWR-1:0]       wen,
    input  logic [NWR*AW-1:0]    waddr,
    input  logic [NWR*XLEN-1:0]  wdata,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    input  logic                 flush,
    output logic [CW-1:0]        busy_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [CW-1:0]   cnt_nxt;
    logic            set_r;
    logic            clr_r;

    // Ascending port order makes the highest-indexed write the final assignment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wen[j] && !(ZERO_R0 != 0 && waddr[j*AW +: AW] == '0)) begin
                    regs[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        busy_nxt = busy;
        set_r    = 1'b0;
        clr_r    = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            set_r = iss_en && (iss_addr == AW'(r));
            clr_r = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                clr_r = clr_r | (wen[j] && (waddr[j*AW +: AW] == AW'(r)));
            end
            busy_nxt[r] = (busy[r] & ~clr_r) | set_r;
        end
        if (ZERO_R0 != 0) begin
            busy_nxt[0] = 1'b0;
        end
        if (flush) begin
            busy_nxt = '0;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // Reads are forced to zero during reset so the bypass path cannot leak wdata.
    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        rd    = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = raddr[k*AW +: AW];
            rd = regs[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wen[j] && waddr[j*AW +: AW] == ra) begin
                        rd = wdata[j*XLEN +: XLEN];
                    end
                end
            end
            if ((ZERO_R0 != 0 && ra == '0) || !rst) begin
                rd = '0;
            end
            rdata[k*XLEN +: XLEN] = rd;
            rbusy[k]              = rst & busy[ra];
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - bench for regfile_mp_sb, bypassed and non-bypassed instances
// Directed vector table, async reset sequence, then random traffic against an array model.
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra [2];
    logic [1:0]  wen;
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;

    logic [9:0]  raddr;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] rd_b, rd_n;
    logic [1:0]  rb_b, rb_n;
    logic [5:0]  cnt_b, cnt_n;

    assign raddr = {ra[1], ra[0]};
    assign waddr = {wa[1], wa[0]};
    assign wdata = {wd[1], wd[0]};

    always #5 clk = ~clk;

    regfile_mp_sb #(.BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rd_b), .rbusy(rb_b),
        .wen(wen), .waddr(waddr), .wdata(wdata), .iss_en(iss_en),
        .iss_addr(iss_addr), .flush(flush), .busy_cnt(cnt_b)
    );

    regfile_mp_sb #(.BYPASS(0)) u_nob (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rd_n), .rbusy(rb_n),
        .wen(wen), .waddr(waddr), .wdata(wdata), .iss_en(iss_en),
        .iss_addr(iss_addr), .flush(flush), .busy_cnt(cnt_n)
    );

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        iss;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  ra0;
        logic [31:0] e_byp, e_nob, e_rd1;
        logic        e_busy;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t tbl [20];
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] m_reg  [32];
    logic        m_busy [32];

    function automatic vec_t mk(
        input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
        input logic [31:0] d0, input logic [31:0] d1, input logic is,
        input logic [4:0] ia, input logic fl, input logic [4:0] r0,
        input logic [31:0] eb, input logic [31:0] en, input logic [31:0] e1,
        input logic ebusy, input logic [5:0] ecnt);
        vec_t v;
        v.wen = w; v.wa0 = a0; v.wa1 = a1; v.wd0 = d0; v.wd1 = d1;
        v.iss = is; v.ia = ia; v.fl = fl; v.ra0 = r0;
        v.e_byp = eb; v.e_nob = en; v.e_rd1 = e1; v.e_busy = ebusy; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        wen = '0; wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    endtask

    initial begin
        logic [31:0] eb [2];
        logic [31:0] en [2];
        int          cnt;

        rst = 1'b0;
        idle();
        ra[0] = 5'd3; ra[1] = 5'd9;
        #2;
        chk("reset_rdata_byp", rd_b, 64'h0);
        chk("reset_rbusy", {62'h0, rb_b}, 64'h0);
        chk("reset_cnt", {58'h0, cnt_b}, 64'h0);

        @(negedge clk);
        rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
            ra[0] = 5'(a); ra[1] = 5'(31 - a);
            #1;
            chk("post_reset_rdata", rd_b, 64'h0);
            chk("post_reset_rbusy", {62'h0, rb_b}, 64'h0);
        end
        chk("post_reset_cnt", {58'h0, cnt_b}, 64'h0);

        tbl[0]  = mk(2'b01, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(2'b01, 5, 0, 32'h12345678, 0, 0, 0, 0, 5, 32'h12345678, 0, 32'h12345678, 0, 0);
        tbl[3]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 32'h12345678, 32'h12345678, 32'h12345678, 0, 0);
        tbl[4]  = mk(2'b11, 7, 7, 32'hAAAA0000, 32'h5555FFFF, 0, 0, 0, 7, 32'h5555FFFF, 0, 32'h12345678, 0, 0);
        tbl[5]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 32'h5555FFFF, 32'h5555FFFF, 32'h12345678, 0, 0);
        tbl[6]  = mk(2'b00, 0, 0, 0, 0, 1, 3, 0, 3, 0, 0, 32'h12345678, 0, 1);
        tbl[7]  = mk(2'b00, 0, 0, 0, 0, 1, 4, 0, 3, 0, 0, 32'h12345678, 1, 2);
        tbl[8]  = mk(2'b01, 3, 0, 32'h33, 0, 0, 0, 0, 3, 32'h33, 0, 32'h12345678, 1, 1);
        tbl[9]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 3, 32'h33, 32'h33, 32'h12345678, 0, 1);
        tbl[10] = mk(2'b01, 4, 0, 32'h44, 0, 1, 4, 0, 4, 32'h44, 0, 32'h12345678, 1, 1);
        tbl[11] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 4, 32'h44, 32'h44, 32'h12345678, 1, 1);
        tbl[12] = mk(2'b01, 4, 0, 32'h44, 0, 1, 1, 0, 4, 32'h44, 32'h44, 32'h12345678, 1, 1);
        tbl[13] = mk(2'b00, 0, 0, 0, 0, 1, 2, 0, 1, 0, 0, 32'h12345678, 1, 2);
        tbl[14] = mk(2'b00, 0, 0, 0, 0, 1, 9, 0, 2, 0, 0, 32'h12345678, 1, 3);
        tbl[15] = mk(2'b00, 0, 0, 0, 0, 1, 10, 1, 9, 0, 0, 32'h12345678, 1, 0);
        tbl[16] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 32'h12345678, 0, 0);
        tbl[17] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 32'h12345678, 0, 0);
        tbl[18] = mk(2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h12345678, 0, 0);
        tbl[19] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h12345678, 0, 0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            wen = tbl[i].wen; wa[0] = tbl[i].wa0; wa[1] = tbl[i].wa1;
            wd[0] = tbl[i].wd0; wd[1] = tbl[i].wd1;
            iss_en = tbl[i].iss; iss_addr = tbl[i].ia; flush = tbl[i].fl;
            ra[0] = tbl[i].ra0; ra[1] = 5'd5;
            #1;
            chk($sformatf("tbl%0d_rd0_byp", i), {32'h0, rd_b[31:0]}, {32'h0, tbl[i].e_byp});
            chk($sformatf("tbl%0d_rd0_nob", i), {32'h0, rd_n[31:0]}, {32'h0, tbl[i].e_nob});
            chk($sformatf("tbl%0d_rd1_byp", i), {32'h0, rd_b[63:32]}, {32'h0, tbl[i].e_rd1});
            chk($sformatf("tbl%0d_rbusy0", i), {63'h0, rb_b[0]}, {63'h0, tbl[i].e_busy});
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_cnt", i), {58'h0, cnt_b}, {58'h0, tbl[i].e_cnt});
            chk($sformatf("tbl%0d_cnt_nob", i), {58'h0, cnt_n}, {58'h0, tbl[i].e_cnt});
        end

        @(negedge clk);
        idle();
        iss_en = 1'b1; iss_addr = 5'd6;
        @(posedge clk);
        #1;
        chk("arst_pre_cnt", {58'h0, cnt_b}, 64'd1);
        @(negedge clk);
        wen = 2'b01; wa[0] = 5'd6; wd[0] = 32'hABC; iss_en = 1'b1; iss_addr = 5'd8;
        ra[0] = 5'd6; ra[1] = 5'd5;
        #1;
        chk("arst_pre_bypass", {32'h0, rd_b[31:0]}, 64'hABC);
        chk("arst_pre_rbusy", {63'h0, rb_b[0]}, 64'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_rdata_byp", rd_b, 64'h0);
        chk("arst_rdata_nob", rd_n, 64'h0);
        chk("arst_rbusy", {60'h0, rb_b, rb_n}, 64'h0);
        chk("arst_cnt", {52'h0, cnt_b, cnt_n}, 64'h0);
        @(posedge clk);
        #1;
        chk("arst_hold_cnt", {58'h0, cnt_b}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        for (int a = 3; a < 8; a++) begin
            ra[0] = 5'(a); ra[1] = 5'(a + 8);
            #1;
            chk($sformatf("arst_after_r%0d", a), rd_n, 64'h0);
            chk($sformatf("arst_after_busy%0d", a), {62'h0, rb_n}, 64'h0);
        end
        chk("arst_after_cnt", {58'h0, cnt_n}, 64'h0);

        for (int r = 0; r < 32; r++) begin
            m_reg[r] = '0;
            m_busy[r] = 1'b0;
        end

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            wen = 2'($urandom);
            for (int j = 0; j < 2; j++) begin
                wa[j] = ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                wd[j] = $urandom;
                ra[j] = ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            end
            iss_en = 1'($urandom);
            iss_addr = ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            flush = ($urandom_range(0, 15) == 0);

            for (int k = 0; k < 2; k++) begin
                en[k] = m_reg[ra[k]];
                eb[k] = m_reg[ra[k]];
                for (int j = 0; j < 2; j++) begin
                    if (wen[j] && wa[j] == ra[k]) eb[k] = wd[j];
                end
                if (ra[k] == 0) begin
                    en[k] = '0;
                    eb[k] = '0;
                end
            end
            #1;
            chk($sformatf("rnd%0d_rd_byp", c), rd_b, {eb[1], eb[0]});
            chk($sformatf("rnd%0d_rd_nob", c), rd_n, {en[1], en[0]});
            chk($sformatf("rnd%0d_rbusy", c), {60'h0, rb_b, rb_n},
                {60'h0, m_busy[ra[1]], m_busy[ra[0]], m_busy[ra[1]], m_busy[ra[0]]});

            @(posedge clk);
            for (int j = 0; j < 2; j++) begin
                if (wen[j] && wa[j] != 0) m_reg[wa[j]] = wd[j];
            end
            if (flush) begin
                for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
            end else begin
                for (int j = 0; j < 2; j++) begin
                    if (wen[j]) m_busy[wa[j]] = 1'b0;
                end
                if (iss_en) m_busy[iss_addr] = 1'b1;
                m_busy[0] = 1'b0;
            end
            cnt = 0;
            for (int r = 0; r < 32; r++) cnt += int'(m_busy[r]);
            #1;
            chk($sformatf("rnd%0d_cnt", c), {52'h0, cnt_b, cnt_n}, {52'h0, 6'(cnt), 6'(cnt)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
